ahb_master_arbiter: RTL and testbench
=====================================

Name: ahb_master_arbiter

Overview:
- Round-robin arbiter and grant scheduler that shares the single AHB-Lite slave port of ahb3lite_apb_bridge among N_MASTERS AHB masters.
- Control only. It drives hgrant and the address-phase and data-phase mux selects (hmaster, hmaster_d) used by the surrounding interconnect.
- Sits between the masters and the bridge, in the HCLK/HRESETn domain.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..8)
- DEFAULT_MASTER, 0, master parked on when nobody requests
- MID_W, $clog2(N_MASTERS), master index width (derived, not overridable)

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- hbusreq  in  N_MASTERS  per-master bus request
- hlock  in  N_MASTERS  per-master locked-sequence request
- htrans  in  2  HTRANS of the current address-phase owner (post-mux)
- hready  in  1  HREADY from the bridge (transfer completing)
- hgrant  out  N_MASTERS  one-hot grant
- hmaster  out  MID_W  address-phase owner index
- hmaster_d  out  MID_W  data-phase owner index (selects HRDATA/HRESP routing)
- hmastlock  out  1  current address-phase transfer is locked

Behaviour:
- Reset values:
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = DEFAULT_MASTER; hmaster_d = DEFAULT_MASTER
  - hmastlock = 0; state = PARK; rr_ptr = 0
- All outputs are registered. The grant decision is taken in cycle n and is visible at the HCLK edge ending cycle n.
- Handover point (HOP): hready=1 AND htrans in {IDLE, NONSEQ} AND state != LOCKED. No grant change is permitted outside a HOP: no break inside a SEQ/BUSY burst and none while hready=0.
- Round-robin selection:
  - Search hbusreq starting at index rr_ptr, wrapping modulo N_MASTERS; the first set bit wins.
  - On every grant to master k: rr_ptr <= (k+1) mod N_MASTERS.
  - If the current owner still requests and others do too, it loses priority to the next requester.
- States:
  - PARK: no hbusreq set. Owner is DEFAULT_MASTER; htrans is expected IDLE. Any request at a HOP goes to GRANTED with the round-robin winner.
  - GRANTED: owner k.
    - At a HOP: re-arbitrate. Winner found -> GRANTED (winner may equal k). No requests -> PARK on DEFAULT_MASTER.
    - If hlock[k]=1 and hbusreq[k]=1 at a HOP -> LOCKED, with owner k kept regardless of other requests.
  - LOCKED: owner fixed, hmastlock=1.
    - Leave when hlock[k]=0 sampled with hready=1. The next HOP then re-arbitrates normally.
    - The transfer in flight while hlock drops still carries hmastlock=1.
- hmaster_d <= hmaster whenever hready=1; it holds while hready=0 (wait states). This gives the AHB one-cycle pipelined data-phase ownership.
- hmastlock <= hlock[winner] on a grant. It clears only on LOCKED exit.
- Simultaneous events: a request asserted and dropped in the same cycle as a HOP is sampled as seen. A master dropping hbusreq mid-burst keeps the grant until the HOP.
- Invariant: hgrant is always exactly one-hot and equals one-hot(hmaster).
- Reset mid-operation: async return to reset values immediately. The in-flight transfer is abandoned; the bridge is reset by the same HRESETn.
- An out-of-range index is impossible by construction. An assertion flags it for non-power-of-2 N_MASTERS.

Decomposition:
- ahb_arb_pkg:
  - htrans_e {IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11}
  - arb_state_e {PARK, GRANTED, LOCKED}
  - function onehot(idx)
- Sub-module ahb_rr_pick: combinational rotate-priority encoder with inputs (req, ptr) and outputs (found, idx). Reused later for the APB slave-select scheduler.

Test Plan:
- Reset then idle: HRESETn low 20 ns, no requests -> hgrant=4'b0001, hmaster=0, hmastlock=0 throughout.
- Round-robin: hbusreq=4'b1111 held, single NONSEQ transfers, hready=1 -> grant order 0,1,2,3,0 on consecutive HOPs.
- Burst protection: master 2 issues NONSEQ+3 SEQ while master 1 requests -> hmaster stays 2 until the SEQ completes, then 1. hmaster_d lags by one hready cycle.
- Wait states: hready=0 for 3 cycles during a handover -> hgrant and hmaster_d frozen; both update on the first hready=1.
- Lock: master 3 with hlock=1 for 4 transfers while hbusreq=4'b1111 -> hmaster=3 and hmastlock=1 until hlock drops; next HOP grants master 0.
- Async reset mid-burst: HRESETn pulsed low while master 2 is in SEQ -> outputs return to reset values within the same cycle, without waiting for an HCLK edge.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared types and helpers for the AHB master arbiter
package ahb_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    PARK    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } arb_state_e;

  function automatic logic [MAX_MASTERS-1:0] onehot(input logic [2:0] idx);
    return MAX_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// rtl/ahb_rr_pick.sv - rotate-priority encoder: first set req bit at or after ptr, wrapping
module ahb_rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  localparam logic [W:0] NW = (W+1)'(N);

  logic [W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (W+1)'(i);
      if (cand >= NW) cand = cand - NW;
      if (req[cand[W-1:0]]) begin
        found = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - round-robin AHB-Lite master arbiter with bus locking
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MID_W         = $clog2(N_MASTERS)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N_MASTERS-1:0] hbusreq,
  input  logic [N_MASTERS-1:0] hlock,
  input  logic [1:0]           htrans,
  input  logic                 hready,
  output logic [N_MASTERS-1:0] hgrant,
  output logic [MID_W-1:0]     hmaster,
  output logic [MID_W-1:0]     hmaster_d,
  output logic                 hmastlock
);

  localparam logic [MID_W-1:0] DEF_IDX = MID_W'(DEFAULT_MASTER);
  localparam logic [MID_W-1:0] LAST_IDX = MID_W'(N_MASTERS - 1);

  arb_state_e       state;
  htrans_e          trans;
  logic [MID_W-1:0] rr_ptr;
  logic [MID_W-1:0] pick_idx;
  logic [MID_W-1:0] ptr_nxt;
  logic             pick_found;
  logic             hop;
  logic             owner_locks;

  assign trans       = htrans_e'(htrans);
  assign hop         = hready && (trans == IDLE || trans == NONSEQ) && state != LOCKED;
  assign owner_locks = state == GRANTED && hlock[hmaster] && hbusreq[hmaster];
  assign ptr_nxt     = (pick_idx == LAST_IDX) ? '0 : pick_idx + MID_W'(1);

  ahb_rr_pick #(.N(N_MASTERS)) u_pick (
    .req   (hbusreq),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= PARK;
      rr_ptr    <= '0;
      hgrant    <= N_MASTERS'(onehot(3'(DEF_IDX)));
      hmaster   <= DEF_IDX;
      hmaster_d <= DEF_IDX;
      hmastlock <= 1'b0;
    end else begin
      if (hready) hmaster_d <= hmaster;
      case (state)
        LOCKED: begin
          // The transfer in flight when hlock drops keeps hmastlock; it clears at this edge.
          if (hready && !hlock[hmaster]) begin
            state     <= GRANTED;
            hmastlock <= 1'b0;
          end
        end
        default: begin
          if (hop) begin
            if (owner_locks) begin
              state     <= LOCKED;
              hmastlock <= 1'b1;
            end else if (pick_found) begin
              state     <= GRANTED;
              rr_ptr    <= ptr_nxt;
              hgrant    <= N_MASTERS'(onehot(3'(pick_idx)));
              hmaster   <= pick_idx;
              hmastlock <= hlock[pick_idx];
            end else begin
              state     <= PARK;
              hgrant    <= N_MASTERS'(onehot(3'(DEF_IDX)));
              hmaster   <= DEF_IDX;
              hmastlock <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  if ((N_MASTERS & (N_MASTERS - 1)) != 0) begin : g_idx_chk
    a_idx_range: assert property (@(posedge HCLK) disable iff (!HRESETn)
      int'(hmaster) < N_MASTERS && int'(hmaster_d) < N_MASTERS);
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - self-checking bench for ahb_master_arbiter
module tb_ahb_master_arbiter;

  localparam int N = 4;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] hbusreq, hlock, hgrant;
  logic [1:0] htrans, hmaster, hmaster_d;
  logic       hready, hmastlock;

  int n_checks = 0;
  int n_errors = 0;

  int m_own, m_own_d, m_ptr;
  bit m_parked, m_locked, m_mlock;

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.N_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_own_d = 0; m_ptr = 0;
    m_parked = 1'b1; m_locked = 1'b0; m_mlock = 1'b0;
  endtask

  // Reference: what ownership looks like after the next clock edge, given this cycle's inputs.
  task automatic model_step(input logic [3:0] req, input logic [3:0] lk,
                            input logic [1:0] tr, input logic rdy);
    bit hop, got;
    int w;
    hop = rdy && (tr == T_IDLE || tr == T_NONSEQ) && !m_locked;
    if (rdy) m_own_d = m_own;
    if (m_locked) begin
      if (rdy && !lk[m_own]) begin
        m_locked = 1'b0;
        m_mlock  = 1'b0;
      end
    end else if (hop) begin
      got = 1'b0; w = 0;
      for (int off = 0; off < N; off++)
        if (!got && req[(m_ptr + off) % N]) begin
          got = 1'b1;
          w   = (m_ptr + off) % N;
        end
      if (!m_parked && lk[m_own] && req[m_own]) begin
        m_locked = 1'b1;
        m_mlock  = 1'b1;
      end else if (got) begin
        m_own = w; m_ptr = (w + 1) % N; m_mlock = lk[w]; m_parked = 1'b0;
      end else begin
        m_own = 0; m_parked = 1'b1; m_mlock = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("hgrant", hgrant, 32'(1) << m_own);
    chk("hmaster", hmaster, m_own);
    chk("hmaster_d", hmaster_d, m_own_d);
    chk("hmastlock", hmastlock, m_mlock);
  endtask

  task automatic cyc(input logic [3:0] req, input logic [3:0] lk,
                     input logic [1:0] tr, input logic rdy);
    hbusreq = req; hlock = lk; htrans = tr; hready = rdy;
    model_step(req, lk, tr, rdy);
    @(negedge HCLK);
    compare_all();
  endtask

  initial begin
    HRESETn = 1'b0; hbusreq = '0; hlock = '0; htrans = T_IDLE; hready = 1'b1;
    model_reset();
    repeat (2) @(negedge HCLK);
    chk("rst_hgrant", hgrant, 4'b0001);
    chk("rst_hmaster", hmaster, 0);
    chk("rst_hmaster_d", hmaster_d, 0);
    chk("rst_hmastlock", hmastlock, 0);
    HRESETn = 1'b1;

    repeat (3) begin
      cyc(4'b0000, 4'b0000, T_IDLE, 1'b1);
      chk("idle_hgrant", hgrant, 4'b0001);
    end

    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
      chk("rr_order", hmaster, rr_exp[i]);
    end

    // Master 2 runs NONSEQ + 3 SEQ while master 1 starts requesting.
    cyc(4'b0100, 4'b0000, T_IDLE, 1'b1);
    chk("burst_grant", hmaster, 2);
    cyc(4'b0100, 4'b0000, T_NONSEQ, 1'b1);
    chk("burst_nonseq", hmaster, 2);
    repeat (3) begin
      cyc(4'b0110, 4'b0000, T_SEQ, 1'b1);
      chk("burst_hold", hmaster, 2);
    end
    cyc(4'b0110, 4'b0000, T_IDLE, 1'b1);
    chk("burst_handover", hmaster, 1);
    chk("burst_data_lag", hmaster_d, 2);

    repeat (3) begin
      cyc(4'b1000, 4'b0000, T_IDLE, 1'b0);
      chk("wait_hgrant", hgrant, 4'b0010);
      chk("wait_hmaster_d", hmaster_d, 2);
    end
    cyc(4'b1000, 4'b0000, T_IDLE, 1'b1);
    chk("wait_release_hgrant", hgrant, 4'b1000);
    chk("wait_release_hmaster_d", hmaster_d, 1);

    repeat (4) begin
      cyc(4'b1111, 4'b1000, T_NONSEQ, 1'b1);
      chk("lock_owner", hmaster, 3);
      chk("lock_flag", hmastlock, 1);
    end
    cyc(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
    chk("lock_exit_owner", hmaster, 3);
    chk("lock_exit_flag", hmastlock, 0);
    cyc(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
    chk("lock_next_grant", hmaster, 0);

    for (int i = 0; i < 600; i++)
      cyc(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
          2'($urandom), $urandom_range(0, 3) != 0);

    // Bring master 2 into a SEQ beat, then reset asynchronously between edges.
    cyc(4'b0000, 4'b0000, T_IDLE, 1'b1);
    cyc(4'b0000, 4'b0000, T_IDLE, 1'b1);
    cyc(4'b0100, 4'b0000, T_IDLE, 1'b1);
    cyc(4'b0100, 4'b0000, T_NONSEQ, 1'b1);
    cyc(4'b0100, 4'b0000, T_SEQ, 1'b1);
    chk("pre_reset_hmaster", hmaster, 2);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_hgrant", hgrant, 4'b0001);
    chk("async_hmaster", hmaster, 0);
    chk("async_hmaster_d", hmaster_d, 0);
    chk("async_hmastlock", hmastlock, 0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    cyc(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
    chk("post_reset_rr", hmaster, 0);
    cyc(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
    chk("post_reset_rr2", hmaster, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
